// File: rtl/mod_blk_assembler16.sv
// Byte-serial to block assembler: packs N bytes from a valid/ready byte stream into one block for the AES256 state register.
// Optional MOD_BLK_FLUSH_EN adds a flush input that closes a partial block early with zero padding.
module mod_blk_assembler16 #(
    parameter  int N  = 16,
    parameter  int W  = 8,
    localparam int CW = $clog2(N) + 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    input  logic                in_sop,
    input  logic [W-1:0]        in_byte,
    output logic                in_ready,
    input  logic                o_ready,
    output logic                o_valid,
    output logic [N-1:0][W-1:0] o_blk,
    output logic [CW-1:0]       byte_cnt,
    output logic                sop_err
`ifdef MOD_BLK_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    typedef enum logic {S_FILL, S_FULL} state_t;

    state_t              state;
    logic                accept;
    logic                transfer;
    logic                restart;
    logic                blk_done;
    logic                flush_now;
    logic [CW-2:0]       wr_idx;
    logic [CW-1:0]       nxt_cnt;
    logic [N-1:0][W-1:0] nxt_blk;

    // A full block accepts a byte only in the cycle it drains, so streaming has no bubble.
    assign in_ready = !resetn && ((state == S_FILL) || o_ready);

    // In FULL byte_cnt is 0, so the same write path stores the first byte of the next block.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        accept    = in_valid && in_ready;
        transfer  = o_valid && o_ready;
        restart   = in_sop && (byte_cnt != '0);
        wr_idx    = restart ? '0 : byte_cnt[CW-2:0];
        nxt_cnt   = byte_cnt;
        nxt_blk   = o_blk;
        flush_now = 1'b0;
        if (accept) begin
            nxt_blk[wr_idx] = in_byte;
            nxt_cnt         = restart ? CW'(1) : byte_cnt + CW'(1);
        end
        blk_done = (nxt_cnt == CW'(N));
`ifdef MOD_BLK_FLUSH_EN
        // Padding starts after any byte stored in the same cycle.
        if ((state == S_FILL) && flush && (nxt_cnt != '0)) begin
            flush_now = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (CW'(i) >= nxt_cnt) begin
                    nxt_blk[i] = '0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state    <= S_FILL;
            byte_cnt <= '0;
            o_blk    <= '0;
            o_valid  <= 1'b0;
            sop_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sop_err <= accept && restart && (state == S_FILL);
            o_blk   <= nxt_blk;
            case (state)
                S_FILL: begin
                    if (blk_done || flush_now) begin
                        state    <= S_FULL;
                        o_valid  <= 1'b1;
                        byte_cnt <= '0;
                    end else begin
                        byte_cnt <= nxt_cnt;
                    end
                end
                S_FULL: begin
                    if (transfer) begin
                        state    <= S_FILL;
                        o_valid  <= 1'b0;
                        byte_cnt <= nxt_cnt;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_blk_assembler16.sv
// Directed bench for mod_blk_assembler16: a vector table for fill/SOP behaviour plus hand-written
// sequences for reset, full-block backpressure, back-to-back streaming and (with MOD_BLK_FLUSH_EN) flush.
module tb_mod_blk_assembler16;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int CW = 5;

    logic                clk = 1'b0;
    logic                resetn;
    logic                in_valid;
    logic                in_sop;
    logic [W-1:0]        in_byte;
    logic                in_ready;
    logic                o_ready;
    logic                o_valid;
    logic [N-1:0][W-1:0] o_blk;
    logic [CW-1:0]       byte_cnt;
    logic                sop_err;
`ifdef MOD_BLK_FLUSH_EN
    logic                flush;
`endif

    int total = 0;
    int bad   = 0;

    mod_blk_assembler16 dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_blk    (o_blk),
        .byte_cnt (byte_cnt),
        .sop_err  (sop_err)
`ifdef MOD_BLK_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          sop;
        logic [7:0]    b;
        logic          rdy;
        logic          x_ready;
        logic          x_valid;
        logic [CW-1:0] x_cnt;
        logic          x_err;
        logic [7:0]    x_b0;
    } vec_t;

    vec_t vecs[9];
    logic [N-1:0][W-1:0] exp_blk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] b, input logic r);
        @(negedge clk);
        in_valid = v;
        in_sop   = s;
        in_byte  = b;
        o_ready  = r;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
    endtask

    initial begin
        resetn   = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_byte  = '0;
        o_ready  = 1'b0;
`ifdef MOD_BLK_FLUSH_EN
        flush    = 1'b0;
`endif

        for (int i = 0; i < 5; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b1, 1'b0, CW'(i + 1), 1'b0, 8'h01};
        end
        vecs[5] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h55};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'h55};
        vecs[7] = '{1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h66};
        vecs[8] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'h66};

        // Reset state, both while held and just after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready during reset", in_ready, 1'b0);
        resetn = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1'b1);
        check("reset o_valid", o_valid, 1'b0);
        check("reset byte_cnt", byte_cnt, '0);
        check("reset o_blk", o_blk, '0);
        check("reset sop_err", sop_err, 1'b0);

        // Partial fill, SOP restart, SOP with valid low.
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].v, vecs[k].sop, vecs[k].b, vecs[k].rdy);
            #1;
            check($sformatf("vec%0d in_ready", k), in_ready, vecs[k].x_ready);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d o_valid", k), o_valid, vecs[k].x_valid);
            check($sformatf("vec%0d byte_cnt", k), byte_cnt, vecs[k].x_cnt);
            check($sformatf("vec%0d sop_err", k), sop_err, vecs[k].x_err);
            check($sformatf("vec%0d o_blk0", k), o_blk[0], vecs[k].x_b0);
        end

        // Asynchronous reset in the middle of a block, between clock edges.
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("pre-reset byte_cnt", byte_cnt, 5'd2);
        resetn = 1'b1;
        #1;
        check("async rst o_valid", o_valid, 1'b0);
        check("async rst byte_cnt", byte_cnt, '0);
        check("async rst o_blk", o_blk, '0);
        check("async rst in_ready", in_ready, 1'b0);
        #1;
        resetn = 1'b0;

        // Fill 00..0F with downstream stalled; o_valid exactly one clock after the last byte.
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("fill%0d o_valid", i), o_valid, (i == N - 1));
            exp_blk[i] = 8'(i);
        end
        check("fill o_blk", o_blk, exp_blk);
        check("fill byte_cnt", byte_cnt, '0);
        check("fill in_ready", in_ready, 1'b0);

        // Backpressure: 8'hAA offered while the block is held.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'hAA, 1'b0);
            #1;
            check($sformatf("bp%0d in_ready", k), in_ready, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d o_blk", k), o_blk, exp_blk);
            check($sformatf("bp%0d o_valid", k), o_valid, 1'b1);
        end
        drive(1'b1, 1'b0, 8'hAA, 1'b1);
        #1;
        check("bp release in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("bp release o_valid", o_valid, 1'b0);
        check("bp release byte_cnt", byte_cnt, 5'd1);
        check("bp release o_blk0", o_blk[0], 8'hAA);
        check("bp release o_blk1 kept", o_blk[1], 8'h01);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // 32 bytes streamed with o_ready high: two blocks, never a stall.
        pulse_reset();
        for (int i = 0; i < 2 * N; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1);
            #1;
            check($sformatf("b2b%0d in_ready", i), in_ready, 1'b1);
            @(posedge clk);
            #1;
            if (i == N - 1 || i == 2 * N - 1) begin
                for (int j = 0; j < N; j++) exp_blk[j] = 8'(i - (N - 1) + j);
                check($sformatf("b2b%0d o_valid", i), o_valid, 1'b1);
                check($sformatf("b2b%0d o_blk", i), o_blk, exp_blk);
            end
            if (i == N) begin
                check("b2b next o_valid", o_valid, 1'b0);
                check("b2b next byte_cnt", byte_cnt, 5'd1);
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        check("b2b drain o_valid", o_valid, 1'b0);
        check("b2b drain byte_cnt", byte_cnt, '0);

`ifdef MOD_BLK_FLUSH_EN
        // Flush after three bytes; stale 10..1F bytes must become zero padding.
        drive(1'b1, 1'b0, 8'h11, 1'b0);
        drive(1'b1, 1'b0, 8'h22, 1'b0);
        drive(1'b1, 1'b0, 8'h33, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        exp_blk = '0;
        exp_blk[0] = 8'h11;
        exp_blk[1] = 8'h22;
        exp_blk[2] = 8'h33;
        check("flush o_valid", o_valid, 1'b1);
        check("flush o_blk", o_blk, exp_blk);
        check("flush byte_cnt", byte_cnt, '0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in FULL drains", o_valid, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
